// File: rtl/rf_pkg.sv
// Shared register-file constants and writeback request types.
package rf_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int REG_COUNT = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_t;

endpackage

// File: rtl/rf_wb_hold.sv
// One-entry valid/ready holding register for a writeback requester.
// Writes to register 0 are accepted and silently dropped.
module rf_wb_hold
  import rf_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              drain,
  output logic              full,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  wb_req_t entry;
  logic    load;

  // Ready includes a same-edge drain so a busy requester keeps full throughput.
  assign in_ready = !full || drain;
  assign load     = in_valid && in_ready && (in_addr != '0);
  assign out_addr = entry.addr;
  assign out_data = entry.data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full  <= 1'b0;
      entry <= '0;
    end else if (load) begin
      full  <= 1'b1;
      entry <= '{addr: in_addr, data: in_data};
    end else if (drain) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbitration of ALU and load writebacks onto the single RF
// write port, plus the per-register busy bitmap used for RAW hazard checks.
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              reserve_valid,
  input  logic [ADDR_W-1:0] reserve_addr,
  input  logic [ADDR_W-1:0] query_addr_s,
  input  logic [ADDR_W-1:0] query_addr_t,
  output logic              busy_s,
  output logic              busy_t,
  output logic              write_enabled,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data
);

  logic              full0, full1;
  logic [ADDR_W-1:0] hold0_addr, hold1_addr;
  logic [DATA_W-1:0] hold0_data, hold1_data;
  logic              grant0, grant1;
  grant_t            last_grant, last_grant_nxt;
  logic [REG_COUNT-1:0] busy, busy_nxt;

  rf_wb_hold u_hold0 (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (req0_valid),
    .in_addr  (req0_addr),
    .in_data  (req0_data),
    .in_ready (req0_ready),
    .drain    (grant0),
    .full     (full0),
    .out_addr (hold0_addr),
    .out_data (hold0_data)
  );

  rf_wb_hold u_hold1 (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (req1_valid),
    .in_addr  (req1_addr),
    .in_data  (req1_data),
    .in_ready (req1_ready),
    .drain    (grant1),
    .full     (full1),
    .out_addr (hold1_addr),
    .out_data (hold1_data)
  );

  // Last-grant state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_grant <= GRANT_REQ1;
    else          last_grant <= last_grant_nxt;
  end

  // Next-state: advance on every grant
  always_comb begin
    last_grant_nxt = last_grant;
    if (grant0)      last_grant_nxt = GRANT_REQ0;
    else if (grant1) last_grant_nxt = GRANT_REQ1;
  end

  // Grant outputs: on contention the requester not granted last wins
  always_comb begin
    grant0 = full0 && (!full1 || (last_grant == GRANT_REQ1));
    grant1 = full1 && (!full0 || (last_grant == GRANT_REQ0));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_enabled <= 1'b0;
      write_addr    <= '0;
      write_data    <= '0;
    end else if (grant0) begin
      write_enabled <= 1'b1;
      write_addr    <= hold0_addr;
      write_data    <= hold0_data;
    end else if (grant1) begin
      write_enabled <= 1'b1;
      write_addr    <= hold1_addr;
      write_data    <= hold1_data;
    end else begin
      write_enabled <= 1'b0;
    end
  end

  // Set is applied after clear so a new reservation survives the old write.
  always_comb begin
    busy_nxt = busy;
    if (write_enabled) busy_nxt[write_addr] = 1'b0;
    if (reserve_valid && (reserve_addr != '0)) busy_nxt[reserve_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  assign busy_s = (query_addr_s != '0) && busy[query_addr_s];
  assign busy_t = (query_addr_t != '0) && busy[query_addr_t];

endmodule
